// File: rtl/noc_credit_repeater_pkg.sv
// Shared types and helpers for the NoC credit repeater.
// Package name noc_pkg is shared with the other NoC blocks.
package noc_pkg;

    localparam int FLIT_WIDTH = 32;
    localparam int DEST_WIDTH = 6;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } flit_t;

    // Width needed to hold 0..credits inclusive
    function automatic int credit_cnt_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/noc_credit_repeater_fifo.sv
// noc_flit_fifo: synchronous flit FIFO with full/empty flags.
// Same-cycle read and write are supported, including a write while full
// when a read frees the slot. There is no bypass: a flit written into an
// empty FIFO becomes visible at the head one cycle later.
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk_noc,
    input  logic  rst_n,
    input  logic  wr_en,
    input  flit_t wr_data,
    input  logic  rd_en,
    output flit_t rd_data,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    flit_t         mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_fire;
    logic          rd_fire;

    // Flag decode from pointers; the extra MSB separates full from empty
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rd_fire = rd_en && !empty;
        wr_fire = wr_en && (!full || rd_fire);
        rd_data = mem[rd_ptr[AW-1:0]];
    end

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk_noc) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; reset flushes by equalising the pointers
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/noc_credit_repeater.sv
// noc_credit_repeater: credit-based link repeater between two routers.
// Buffers flits, returns one upstream credit per flit forwarded, and keeps
// its own credit count toward the downstream router.
// Optional feature macro: NOC_REPEATER_ERR_CHECK_EN enables the sticky err
// flag (FIFO overflow, downstream credit overflow) and matching sim checks.
// The flit fields use noc_pkg::flit_t, so FLIT_WIDTH/DEST_WIDTH must match
// the package widths.
module noc_credit_repeater #(
    parameter int FLIT_WIDTH         = 32,
    parameter int DEST_WIDTH         = 6,
    parameter int BUFFER_DEPTH       = 8,
    parameter int DOWNSTREAM_CREDITS = 8
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic                  err
);

    import noc_pkg::*;

    localparam int                CNT_W   = credit_cnt_width(DOWNSTREAM_CREDITS);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DOWNSTREAM_CREDITS);

    flit_t            wr_flit;
    flit_t            head_flit;
    logic             full;
    logic             empty;
    logic             issue;
    logic             cnt_full;
    logic [CNT_W-1:0] cnt;

    // Pop the head whenever something is buffered and downstream has room
    always_comb begin
        wr_flit.data    = data_in;
        wr_flit.dest    = dest_in;
        wr_flit.is_tail = is_tail_in;
        issue           = !empty && (cnt != '0);
        cnt_full        = (cnt == CNT_MAX);
    end

    noc_flit_fifo #(
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk_noc (clk_noc),
        .rst_n   (rst_n),
        .wr_en   (send_in),
        .wr_data (wr_flit),
        .rd_en   (issue),
        .rd_data (head_flit),
        .full    (full),
        .empty   (empty)
    );

    // Downstream credit counter; an excess credit saturates at the maximum
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            cnt <= CNT_MAX;
        end else if (issue && !credit_in) begin
            cnt <= cnt - CNT_W'(1);
        end else if (!issue && credit_in && !cnt_full) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Output registers; flit fields hold their value between sends
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            send_out    <= 1'b0;
            credit_out  <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
        end else begin
            send_out   <= issue;
            credit_out <= issue;
            if (issue) begin
                data_out    <= head_flit.data;
                dest_out    <= head_flit.dest;
                is_tail_out <= head_flit.is_tail;
            end
        end
    end

`ifdef NOC_REPEATER_ERR_CHECK_EN
    logic overflow;
    logic credit_sat;
    logic err_q;

    // A write is lost only when full and nothing leaves this cycle
    always_comb begin
        overflow   = send_in && full && !issue;
        credit_sat = credit_in && cnt_full;
    end

    // Sticky violation flag, cleared only by reset
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (overflow || credit_sat) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

    // Simulation-time report of protocol violations from either neighbour
    always @(posedge clk_noc) begin
        if (rst_n) begin
            assert (!overflow)
                else $warning("noc_credit_repeater: upstream wrote into a full buffer");
            assert (!credit_sat)
                else $warning("noc_credit_repeater: downstream returned an excess credit");
        end
    end
`else
    logic unused_full;

    assign unused_full = full;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_noc_credit_repeater.sv
// Directed testbench for noc_credit_repeater with a flit scoreboard.
module tb_noc_credit_repeater;

`ifdef NOC_REPEATER_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk_noc = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic [5:0]  dest_in;
    logic        is_tail_in;
    logic        send_in;
    logic        credit_out;
    logic [31:0] data_out;
    logic [5:0]  dest_out;
    logic        is_tail_out;
    logic        send_out;
    logic        credit_in;
    logic        err;

    int          vectors     = 0;
    int          miscompares = 0;
    int          n_send      = 0;
    int          n_cred      = 0;
    int          cycle_no    = 0;
    logic [38:0] sb [$];

    always #5 clk_noc = ~clk_noc;

    noc_credit_repeater #(
        .FLIT_WIDTH         (32),
        .DEST_WIDTH         (6),
        .BUFFER_DEPTH       (8),
        .DOWNSTREAM_CREDITS (8)
    ) dut (
        .clk_noc     (clk_noc),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .dest_in     (dest_in),
        .is_tail_in  (is_tail_in),
        .send_in     (send_in),
        .credit_out  (credit_out),
        .data_out    (data_out),
        .dest_out    (dest_out),
        .is_tail_out (is_tail_out),
        .send_out    (send_out),
        .credit_in   (credit_in),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                miscompares++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            end
    endtask

    function automatic logic [38:0] mk(input int i);
        logic [31:0] d;
        logic [5:0]  t;
        d = 32'hC000_0000 + 32'(i);
        t = 6'(i);
        return {d, t, (i % 4) == 3};
    endfunction

    task automatic drive(input logic s, input logic [38:0] f, input logic c);
        send_in                          = s;
        {data_in, dest_in, is_tail_in}   = f;
        credit_in                        = c;
    endtask

    // Advance one clock, then check outputs against the scoreboard
    task automatic cyc();
        logic [38:0] exp;
        @(posedge clk_noc);
        #1;
        cycle_no++;
        if (send_out) begin
            n_send++;
            vectors++;
            assert (sb.size() > 0)
                else begin
                    miscompares++;
                    $error("FAIL sb_underflow: send_out=1 observed, expected 0 (no flit pending)");
                end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("flit_order", {data_out, dest_out, is_tail_out}, exp);
            end
        end
        if (credit_out) n_cred++;
        chk("credit_with_send", credit_out, send_out);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        sb.delete();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int          base;
        int          cbase;
        int          first;
        int          last;
        logic [2:0]  dl;

        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        cyc();
        cyc();
        chk("rst_outputs", {data_out, dest_out, is_tail_out, send_out, credit_out, err}, '0);
        chk("rst_cnt", dut.cnt, 8);
        rst_n = 1'b1;

        // Single flit latency
        drive(1'b1, {32'hA5A5A5A5, 6'h12, 1'b1}, 1'b0);
        sb.push_back({32'hA5A5A5A5, 6'h12, 1'b1});
        cyc();
        chk("lat_cycle1_send", send_out, 0);
        drive(1'b0, '0, 1'b0);
        cyc();
        chk("lat_cycle2_send", send_out, 1);
        chk("lat_cycle2_credit", credit_out, 1);
        chk("lat_cnt", dut.cnt, 7);
        cyc();
        chk("hold_send", send_out, 0);
        chk("hold_data", {data_out, dest_out, is_tail_out}, {32'hA5A5A5A5, 6'h12, 1'b1});

        // No downstream credits: 8 out then stall, 4 credits release 4 more
        do_reset();
        base = n_send;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, mk(i), 1'b0);
            sb.push_back(mk(i));
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        repeat (6) cyc();
        chk("stall_sends", n_send - base, 8);
        chk("stall_cnt", dut.cnt, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        repeat (4) cyc();
        chk("release_sends", n_send - base, 12);
        chk("release_sb_empty", sb.size(), 0);
        chk("release_err", err, 0);

        // Overflow: fill 8 with no credits, ninth write is dropped
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, mk(40 + i), 1'b0);
            sb.push_back(mk(40 + i));
            cyc();
        end
        cbase = n_cred;
        base  = n_send;
        drive(1'b1, mk(99), 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0);
        cyc();
        chk("ovf_err", err, ERR_EN);
        repeat (3) cyc();
        chk("ovf_err_sticky", err, ERR_EN);
        chk("ovf_no_credit", n_cred - cbase, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1);
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        repeat (4) cyc();
        chk("ovf_drain_sends", n_send - base, 8);
        chk("ovf_drain_credits", n_cred - cbase, 8);
        chk("ovf_sb_empty", sb.size(), 0);

        // Credit saturation at cnt == 8
        do_reset();
        chk("sat_err_clear", err, 0);
        drive(1'b0, '0, 1'b1);
        cyc();
        drive(1'b0, '0, 1'b0);
        cyc();
        chk("sat_cnt", dut.cnt, 8);
        chk("sat_err", err, ERR_EN);

        // Streaming 100 flits with credits looped back after 3 cycles
        do_reset();
        base  = n_send;
        cbase = n_cred;
        first = -1;
        last  = -1;
        dl    = '0;
        for (int k = 0; k < 140; k++) begin
            drive(k < 100, mk(200 + k), dl[2]);
            if (k < 100) sb.push_back(mk(200 + k));
            cyc();
            if (send_out) begin
                if (first < 0) first = cycle_no;
                last = cycle_no;
            end
            dl = {dl[1:0], send_out};
        end
        drive(1'b0, '0, 1'b0);
        chk("stream_sends", n_send - base, 100);
        chk("stream_credits", n_cred - cbase, 100);
        chk("stream_span", last - first, 99);
        chk("stream_sb_empty", sb.size(), 0);
        chk("stream_cnt", dut.cnt, 8);
        chk("stream_err", err, 0);

        // Reset while 5 flits are buffered
        base = n_send;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, mk(400 + i), 1'b0);
            sb.push_back(mk(400 + i));
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        repeat (3) cyc();
        chk("pre_flush_sends", n_send - base, 8);
        cbase = n_cred;
        do_reset();
        chk("flush_outputs", {data_out, dest_out, is_tail_out, send_out, credit_out, err}, '0);
        chk("flush_cnt", dut.cnt, 8);
        drive(1'b1, mk(500), 1'b0);
        sb.push_back(mk(500));
        cyc();
        chk("post_flush_c1", send_out, 0);
        drive(1'b0, '0, 1'b0);
        cyc();
        chk("post_flush_c2", send_out, 1);
        repeat (4) cyc();
        chk("post_flush_credits", n_cred - cbase, 1);
        chk("post_flush_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
